// File: rtl/mem_access_ctrl.sv
// Sequencer between the MEM stage and the cache/main-memory system: issues lookup
// strobes, waits out miss latency, pulses the refill commit, retries, returns load data.
module mem_access_ctrl #(
    parameter int MISS_LATENCY  = 20,
    parameter int DIRTY_PENALTY = 20,
    parameter int MAX_RETRY     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic        err_o,
    output logic        cache_re,
    output logic        cache_we,
    output logic        cache_we2,
    output logic        cache_we3,
    output logic [31:0] cache_addr,
    output logic [31:0] cache_wdata,
    input  logic [31:0] cache_rdata,
    input  logic        cache_hit,
    input  logic        cache_miss,
    input  logic        cache_dirty,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOOKUP   = 3'd1;
    localparam logic [2:0] WAIT_MEM = 3'd2;
    localparam logic [2:0] FILL     = 3'd3;
    localparam logic [2:0] RETRY    = 3'd4;

    localparam int CNT_W = $clog2(MISS_LATENCY + DIRTY_PENALTY + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    logic [2:0]       state;
    logic             is_store;
    logic [CNT_W-1:0] cnt;
    logic [RTY_W-1:0] retry_cnt;

    logic             req;
    logic             in_lookup;
    logic             lk_hit;
    logic [CNT_W-1:0] miss_wait;

    // Handshake: a request (memread_i|memwrite_i) is held stable while stall_o=1;
    // it completes on the first rising edge where the request sees stall_o=0.
    assign req       = memread_i | memwrite_i;
    assign in_lookup = (state == LOOKUP) || (state == RETRY);
    // A strobe answered with neither (or both) hit and miss is handled as a miss.
    assign lk_hit    = cache_hit & ~cache_miss;
    assign miss_wait = cache_dirty ? CNT_W'(MISS_LATENCY + DIRTY_PENALTY - 1)
                                   : CNT_W'(MISS_LATENCY - 1);

    assign cache_re  = in_lookup && !is_store;
    assign cache_we  = in_lookup && is_store;
    assign cache_we2 = (state == FILL) && is_store;
    assign cache_we3 = (state == FILL) && !is_store;
    assign dbg_state = state;

    always_comb begin
        stall_o = 1'b0;
        case (state)
            IDLE:           stall_o = req;
            LOOKUP, RETRY:  stall_o = !lk_hit;
            WAIT_MEM, FILL: stall_o = 1'b1;
            default:        stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            is_store    <= 1'b0;
            cnt         <= '0;
            retry_cnt   <= '0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            rdata_o     <= '0;
            rvalid_o    <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            rvalid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        cache_addr  <= addr_i;
                        cache_wdata <= wdata_i;
                        is_store    <= memwrite_i;
                        retry_cnt   <= '0;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP, RETRY: begin
                    if (lk_hit) begin
                        if (!is_store) begin
                            rdata_o  <= cache_rdata;
                            rvalid_o <= 1'b1;
                        end
                        state <= IDLE;
                    end else if ((state == RETRY) && (retry_cnt == RTY_W'(MAX_RETRY - 1))) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        err_o     <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        if (state == RETRY) begin
                            retry_cnt <= retry_cnt + 1'b1;
                        end
                        cnt   <= miss_wait;
                        state <= WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    if (cnt == '0) begin
                        state <= FILL;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FILL:    state <= RETRY;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a behavioural memory_system responder plus a
// transaction-level reference model predicting latency, strobe counts, load data and errors.
module tb_mem_access_ctrl;

    localparam int MISS_LATENCY  = 20;
    localparam int DIRTY_PENALTY = 20;
    localparam int MAX_RETRY     = 2;

    localparam int SC_HIT   = 0;
    localparam int SC_CLEAN = 1;
    localparam int SC_DIRTY = 2;
    localparam int SC_STUCK = 3;

    logic        clk;
    logic        reset_n;
    logic        memread_i;
    logic        memwrite_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        err_o;
    logic        cache_re;
    logic        cache_we;
    logic        cache_we2;
    logic        cache_we3;
    logic [31:0] cache_addr;
    logic [31:0] cache_wdata;
    logic [31:0] cache_rdata;
    logic        cache_hit;
    logic        cache_miss;
    logic        cache_dirty;
    logic [2:0]  dbg_state;

    int scen  = SC_HIT;
    int fills = 0;

    logic [31:0] mem [256];
    logic [255:0] written = '0;
    logic [31:0] ref_mem [256];
    logic [255:0] ref_written = '0;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [7:0] idx_of(input logic [31:0] a);
        return a[9:2] ^ a[17:10];
    endfunction

    function automatic logic [31:0] init_word(input logic [7:0] i);
        return {i, ~i, 8'h5a, i};
    endfunction

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl #(
        .MISS_LATENCY (MISS_LATENCY),
        .DIRTY_PENALTY(DIRTY_PENALTY),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .memread_i  (memread_i),
        .memwrite_i (memwrite_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .stall_o    (stall_o),
        .rdata_o    (rdata_o),
        .rvalid_o   (rvalid_o),
        .err_o      (err_o),
        .cache_re   (cache_re),
        .cache_we   (cache_we),
        .cache_we2  (cache_we2),
        .cache_we3  (cache_we3),
        .cache_addr (cache_addr),
        .cache_wdata(cache_wdata),
        .cache_rdata(cache_rdata),
        .cache_hit  (cache_hit),
        .cache_miss (cache_miss),
        .cache_dirty(cache_dirty),
        .dbg_state  (dbg_state)
    );

    // ---------------- memory_system responder ----------------
    // Scenario decides hit/miss; any non-stuck line hits once a refill has been committed.
    always_comb begin
        logic look;
        logic hit_now;
        look        = cache_re | cache_we;
        hit_now     = (scen == SC_HIT) || ((scen != SC_STUCK) && (fills > 0));
        cache_hit   = look && hit_now;
        cache_miss  = look && !hit_now;
        cache_dirty = look && !hit_now && (scen == SC_DIRTY);
        cache_rdata = written[idx_of(cache_addr)] ? mem[idx_of(cache_addr)]
                                                  : init_word(idx_of(cache_addr));
    end

    always @(posedge clk) begin
        if (cache_we && cache_hit) begin
            mem[idx_of(cache_addr)]     <= cache_wdata;
            written[idx_of(cache_addr)] <= 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_written[idx_of(a)] ? ref_mem[idx_of(a)] : init_word(idx_of(a));
    endfunction

    // ---------------- driver ----------------
    // Entered and left at a falling edge; the next request may follow with no gap.
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input int sc);
        int   cycles = 0;
        int   n_re = 0, n_we = 0, n_we2 = 0, n_we3 = 0, n_excl = 0;
        logic done = 1'b0, err_seen = 1'b0, err_before, fill_now;
        logic st;
        int   nmiss, wait_c, exp_lat, exp_fills;
        st         = wr;
        err_before = err_o;
        scen       = sc;
        fills      = 0;
        memread_i  = rd;
        memwrite_i = wr;
        addr_i     = a;
        wdata_i    = d;
        while (!done && cycles < 200) begin
            #1;
            n_re  += int'(cache_re);
            n_we  += int'(cache_we);
            n_we2 += int'(cache_we2);
            n_we3 += int'(cache_we3);
            if (int'(cache_re) + int'(cache_we) + int'(cache_we2) + int'(cache_we3) > 1) n_excl++;
            if (!stall_o) done = 1'b1;
            fill_now = cache_we2 | cache_we3;
            @(posedge clk);
            cycles++;
            if (fill_now) fills++;
            @(negedge clk);
            if (err_o && !err_before) begin
                done     = 1'b1;
                err_seen = 1'b1;
            end
        end
        memread_i  = 1'b0;
        memwrite_i = 1'b0;
        check("done", 32'(done), 32'd1);

        if (sc == SC_STUCK) begin
            exp_fills = MAX_RETRY;
            exp_lat   = 2 + MAX_RETRY * (MISS_LATENCY + 2);
        end else begin
            nmiss     = (sc == SC_HIT) ? 0 : 1;
            wait_c    = (sc == SC_DIRTY) ? MISS_LATENCY + DIRTY_PENALTY : MISS_LATENCY;
            exp_fills = nmiss;
            exp_lat   = 2 + nmiss * (wait_c + 2);
        end
        check("latency", 32'(cycles), 32'(exp_lat));
        check("re_cnt",  32'(n_re),  st ? 32'd0 : 32'(exp_fills + 1));
        check("we_cnt",  32'(n_we),  st ? 32'(exp_fills + 1) : 32'd0);
        check("we2_cnt", 32'(n_we2), st ? 32'(exp_fills) : 32'd0);
        check("we3_cnt", 32'(n_we3), st ? 32'd0 : 32'(exp_fills));
        check("strobe_excl", 32'(n_excl), 32'd0);
        check("err_rise", 32'(err_seen), (sc == SC_STUCK) ? 32'd1 : 32'd0);
        check("rvalid", 32'(rvalid_o), (!st && sc != SC_STUCK) ? 32'd1 : 32'd0);
        if (!st && sc != SC_STUCK) check("rdata", rdata_o, ref_read(a));
        if (st && sc != SC_STUCK) begin
            ref_mem[idx_of(a)]     = d;
            ref_written[idx_of(a)] = 1'b1;
        end
    endtask

    task automatic run_random(input int n);
        int op;
        for (int i = 0; i < n; i++) begin
            op = $urandom_range(0, 2);
            run_req(op != 1, op != 0, 32'($urandom_range(0, 1023)), $urandom,
                    $urandom_range(SC_HIT, SC_DIRTY));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses;
        reset_n    = 1'b0;
        memread_i  = 1'b0;
        memwrite_i = 1'b0;
        addr_i     = '0;
        wdata_i    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_strobes", {28'd0, cache_re, cache_we, cache_we2, cache_we3}, 32'd0);
        check("rst_addr", cache_addr, 32'd0);
        check("rst_rvalid_err", {30'd0, rvalid_o, err_o}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_req(1'b0, 1'b1, 32'h0000_4012, 32'h1234_5678, SC_CLEAN);
        run_req(1'b1, 1'b0, 32'h0000_4012, 32'h0, SC_HIT);
        check("load_hit_data", rdata_o, 32'h1234_5678);
        run_req(1'b1, 1'b0, 32'h0000_8012, 32'h0, SC_DIRTY);
        run_req(1'b1, 1'b1, 32'h0000_8011, 32'h8765_4321, SC_HIT);
        run_req(1'b1, 1'b0, 32'h0000_8010, 32'h0, SC_HIT);
        check("both_is_store", rdata_o, 32'h8765_4321);
        run_random(20);

        run_req(1'b1, 1'b0, 32'h0000_0120, 32'h0, SC_STUCK);
        @(negedge clk);
        check("err_sticky", 32'(err_o), 32'd1);
        check("err_no_rvalid", 32'(rvalid_o), 32'd0);

        // Asynchronous reset landing in WAIT_MEM with five wait cycles left.
        scen      = SC_CLEAN;
        fills     = 0;
        memread_i = 1'b1;
        addr_i    = 32'h0000_0200;
        repeat (16) @(posedge clk);
        #2;
        reset_n   = 1'b0;
        memread_i = 1'b0;
        #1;
        check("arst_stall", 32'(stall_o), 32'd0);
        check("arst_strobes", {28'd0, cache_re, cache_we, cache_we2, cache_we3}, 32'd0);
        check("arst_addr", cache_addr, 32'd0);
        check("arst_wdata", cache_wdata, 32'd0);
        check("arst_rdata", rdata_o, 32'd0);
        check("arst_rvalid_err", {30'd0, rvalid_o, err_o}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pulses  = 0;
        repeat (30) begin
            @(negedge clk);
            pulses += int'(cache_we2) + int'(cache_we3);
        end
        check("arst_no_refill", 32'(pulses), 32'd0);
        run_req(1'b1, 1'b0, 32'h0000_4012, 32'h0, SC_HIT);
        run_random(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
